// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM and its
// instruction-class decoder.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXE,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ADDU,
    CL_SUBU,
    CL_SLL,
    CL_JR,
    CL_ORI,
    CL_ADDIU,
    CL_LUI,
    CL_LW,
    CL_SW,
    CL_BEQ,
    CL_J,
    CL_JAL,
    CL_ILL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;

  localparam logic [1:0] EXT_ZERO  = 2'b00;
  localparam logic [1:0] EXT_SIGN  = 2'b01;
  localparam logic [1:0] EXT_UPPER = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] SRC2_RT  = 2'b00;
  localparam logic [1:0] SRC2_IMM = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  // Full datapath control word; the all-zero value is the idle/safe setting.
  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_rtype_alu(input iclass_e c);
    return (c == CL_ADDU) || (c == CL_SUBU) || (c == CL_SLL);
  endfunction

  function automatic logic is_mem_class(input iclass_e c);
    return (c == CL_LW) || (c == CL_SW);
  endfunction

endpackage

// File: rtl/mc_instr_decode.sv
// Combinational opcode/funct decoder: maps the held instruction fields to an
// instruction class. Anything not recognised is reported as CL_ILL.
module mc_instr_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_funct,
  output logic [3:0] o_class
);

  iclass_e w_class;

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    w_class = CL_ILL;
    case (i_op)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: w_class = CL_ADDU;
          FN_SUBU: w_class = CL_SUBU;
          FN_SLL:  w_class = CL_SLL;
          FN_JR:   w_class = CL_JR;
          default: w_class = CL_ILL;
        endcase
      end
      OP_ORI:   w_class = CL_ORI;
      OP_ADDIU: w_class = CL_ADDIU;
      OP_LUI:   w_class = CL_LUI;
      OP_LW:    w_class = CL_LW;
      OP_SW:    w_class = CL_SW;
      OP_BEQ:   w_class = CL_BEQ;
      OP_J:     w_class = CL_J;
      OP_JAL:   w_class = CL_JAL;
      default:  w_class = CL_ILL;
    endcase
  end

  assign o_class = w_class;

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXE/MEM/WB per
// instruction class, drives datapath control and counts retired instructions.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int TRAP_HALT     = 1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ir_we,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       alu_op,
  output logic [1:0]       ext_op,
  output logic [1:0]       reg_dst,
  output logic             alu_src1,
  output logic [1:0]       alu_src2,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           r_state;
  iclass_e          r_class;
  logic [CNT_W-1:0] r_retired;

  logic [3:0] w_dec_raw;
  iclass_e    w_dec_class;
  logic       w_mem_done;
  ctrl_t      w_ctrl;

  mc_instr_decode u_decode (
    .i_op    (op),
    .i_funct (funct),
    .o_class (w_dec_raw)
  );

  assign w_dec_class = iclass_e'(w_dec_raw);

  // Without the handshake every memory access completes in its first cycle.
  assign w_mem_done = (MEM_HANDSHAKE == 0) || mem_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_class   <= CL_NOP;
      r_retired <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;

        ST_FETCH: begin
          if (w_mem_done) r_state <= ST_DECODE;
        end

        ST_DECODE: begin
          r_class <= w_dec_class;
          case (w_dec_class)
            CL_J, CL_JR: begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end
            CL_JAL: r_state <= ST_WB;
            CL_ILL: begin
              if (TRAP_HALT != 0) begin
                r_state <= ST_TRAP;
              end else begin
                r_state   <= ST_FETCH;
                r_retired <= r_retired + CNT_W'(1);
              end
            end
            default: r_state <= ST_EXE;
          endcase
        end

        ST_EXE: begin
          if (is_mem_class(r_class)) begin
            r_state <= ST_MEM;
          end else if (r_class == CL_BEQ) begin
            r_state   <= ST_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end else begin
            r_state <= ST_WB;
          end
        end

        ST_MEM: begin
          if (w_mem_done) begin
            if (r_class == CL_LW) begin
              r_state <= ST_WB;
            end else begin
              r_state   <= ST_FETCH;
              r_retired <= r_retired + CNT_W'(1);
            end
          end
        end

        ST_WB: begin
          r_state   <= ST_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end

        ST_TRAP: r_state <= ST_TRAP;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Control word is a function of state and class; DECODE uses the live
  // decode because the class register only loads at the end of that cycle.
  always_comb begin
    w_ctrl = '0;
    case (r_state)
      ST_FETCH: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.ir_we    = w_mem_done;
        w_ctrl.pc_we    = w_mem_done;
        w_ctrl.pc_src   = PC_SEQ;
      end

      ST_DECODE: begin
        case (w_dec_class)
          CL_J: begin
            w_ctrl.pc_we  = 1'b1;
            w_ctrl.pc_src = PC_JUMP;
          end
          CL_JR: begin
            w_ctrl.pc_we  = 1'b1;
            w_ctrl.pc_src = PC_REG;
          end
          default: ;
        endcase
      end

      ST_EXE: begin
        case (r_class)
          CL_ADDU: w_ctrl.alu_op = ALU_ADD;
          CL_SUBU: w_ctrl.alu_op = ALU_SUB;
          CL_SLL: begin
            w_ctrl.alu_op   = ALU_SLL;
            w_ctrl.alu_src1 = 1'b1;
          end
          CL_ORI: begin
            w_ctrl.alu_op   = ALU_OR;
            w_ctrl.ext_op   = EXT_ZERO;
            w_ctrl.alu_src2 = SRC2_IMM;
          end
          CL_ADDIU, CL_LW, CL_SW: begin
            w_ctrl.alu_op   = ALU_ADD;
            w_ctrl.ext_op   = EXT_SIGN;
            w_ctrl.alu_src2 = SRC2_IMM;
          end
          CL_LUI: begin
            w_ctrl.alu_op   = ALU_OR;
            w_ctrl.ext_op   = EXT_UPPER;
            w_ctrl.alu_src2 = SRC2_IMM;
          end
          CL_BEQ: begin
            w_ctrl.alu_op   = ALU_SUB;
            w_ctrl.alu_src2 = SRC2_RT;
            w_ctrl.pc_we    = zero;
            w_ctrl.pc_src   = PC_BRANCH;
          end
          default: w_ctrl.alu_op = ALU_NONE;
        endcase
      end

      ST_MEM: begin
        w_ctrl.mem_read  = (r_class == CL_LW);
        w_ctrl.mem_write = (r_class == CL_SW);
      end

      ST_WB: begin
        w_ctrl.reg_write = 1'b1;
        if (is_rtype_alu(r_class)) begin
          w_ctrl.reg_dst = DST_RD;
        end else if (r_class == CL_LW) begin
          w_ctrl.mem_to_reg = WB_MEM;
        end else if (r_class == CL_JAL) begin
          w_ctrl.reg_dst    = DST_RA;
          w_ctrl.mem_to_reg = WB_PC4;
          w_ctrl.pc_we      = 1'b1;
          w_ctrl.pc_src     = PC_JUMP;
        end
      end

      ST_TRAP: w_ctrl.illegal = 1'b1;

      default: ;
    endcase
  end

  assign pc_we      = w_ctrl.pc_we;
  assign ir_we      = w_ctrl.ir_we;
  assign reg_write  = w_ctrl.reg_write;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_write  = w_ctrl.mem_write;
  assign alu_op     = w_ctrl.alu_op;
  assign ext_op     = w_ctrl.ext_op;
  assign reg_dst    = w_ctrl.reg_dst;
  assign alu_src1   = w_ctrl.alu_src1;
  assign alu_src2   = w_ctrl.alu_src2;
  assign mem_to_reg = w_ctrl.mem_to_reg;
  assign pc_src     = w_ctrl.pc_src;
  assign illegal    = w_ctrl.illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: two configurations share stimulus;
// per-cycle expected control words are queued and compared one per cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic [1:0] reg_dst;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t       c;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] ret;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        pc_we0, ir_we0, reg_write0, mem_read0, mem_write0, alu_src10, illegal0;
  logic [2:0]  alu_op0;
  logic [1:0]  ext_op0, reg_dst0, alu_src20, mem_to_reg0, pc_src0;
  logic [31:0] retired0;
  logic        pc_we1, ir_we1, reg_write1, mem_read1, mem_write1, alu_src11, illegal1;
  logic [2:0]  alu_op1;
  logic [1:0]  ext_op1, reg_dst1, alu_src21, mem_to_reg1, pc_src1;
  logic [3:0]  retired1;

  int sel = 0;
  int n_checks = 0;
  int n_errors = 0;
  int ret_model = 0;
  exp_t  q[$];
  string tq[$];

  ctrl_t       obs0, obs1, obs;
  logic [31:0] obs_ret;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_HANDSHAKE(0), .TRAP_HALT(1), .CNT_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we0), .ir_we(ir_we0), .reg_write(reg_write0), .mem_read(mem_read0),
    .mem_write(mem_write0), .alu_op(alu_op0), .ext_op(ext_op0), .reg_dst(reg_dst0),
    .alu_src1(alu_src10), .alu_src2(alu_src20), .mem_to_reg(mem_to_reg0), .pc_src(pc_src0),
    .illegal(illegal0), .retired(retired0)
  );

  multicycle_control #(.MEM_HANDSHAKE(1), .TRAP_HALT(0), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_we(pc_we1), .ir_we(ir_we1), .reg_write(reg_write1), .mem_read(mem_read1),
    .mem_write(mem_write1), .alu_op(alu_op1), .ext_op(ext_op1), .reg_dst(reg_dst1),
    .alu_src1(alu_src11), .alu_src2(alu_src21), .mem_to_reg(mem_to_reg1), .pc_src(pc_src1),
    .illegal(illegal1), .retired(retired1)
  );

  assign obs0 = {pc_we0, ir_we0, reg_write0, mem_read0, mem_write0, alu_op0, ext_op0,
                 reg_dst0, alu_src10, alu_src20, mem_to_reg0, pc_src0, illegal0};
  assign obs1 = {pc_we1, ir_we1, reg_write1, mem_read1, mem_write1, alu_op1, ext_op1,
                 reg_dst1, alu_src11, alu_src21, mem_to_reg1, pc_src1, illegal1};
  assign obs     = (sel == 1) ? obs1 : obs0;
  assign obs_ret = (sel == 1) ? {28'b0, retired1} : retired0;

  function automatic logic [31:0] w32(input ctrl_t c);
    return {12'b0, c};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input string tag, input ctrl_t c, input logic mr, input logic z,
                      input logic [5:0] o, input logic [5:0] f);
    exp_t e;
    e.c   = c;
    e.mr  = mr;
    e.z   = z;
    e.op  = o;
    e.fn  = f;
    e.ret = 32'(ret_model) & ((sel == 1) ? 32'h0000_000F : 32'hFFFF_FFFF);
    q.push_back(e);
    tq.push_back(tag);
  endtask

  task automatic drain();
    exp_t  e;
    string t;
    while (q.size() > 0) begin
      e = q.pop_front();
      t = tq.pop_front();
      @(negedge clk);
      mem_ready = e.mr;
      zero      = e.z;
      op        = e.op;
      funct     = e.fn;
      #1;
      check({t, ".ctl"}, w32(obs), w32(e.c));
      check({t, ".ret"}, obs_ret, e.ret);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, ".rst_ctl"}, w32(obs), 32'h0);
    check({tag, ".rst_ret"}, obs_ret, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check({tag, ".idle_ctl"}, w32(obs), 32'h0);
    ret_model = 0;
  endtask

  // Expected per-cycle control for one instruction, starting at its FETCH.
  // abort_mem stops after mwait stalled MEM cycles (caller then resets).
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int fwait, input int mwait,
                           input bit abort_mem);
    ctrl_t c;
    bit    has_exe, has_mem, has_wb, retire;
    has_exe = !(name == "j" || name == "jr" || name == "jal" || name == "ill");
    has_mem = (name == "lw" || name == "sw");
    has_wb  = !(name == "j" || name == "jr" || name == "beq" || name == "sw" || name == "ill");
    retire  = 1'b1;

    for (int i = 0; i < fwait; i++) begin
      c = '0; c.mem_read = 1'b1;
      push({name, ".Fwait"}, c, 1'b0, z, o, f);
    end
    c = '0; c.mem_read = 1'b1; c.ir_we = 1'b1; c.pc_we = 1'b1;
    push({name, ".F"}, c, 1'b1, z, o, f);

    c = '0;
    if (name == "j")  begin c.pc_we = 1'b1; c.pc_src = 2'b10; end
    if (name == "jr") begin c.pc_we = 1'b1; c.pc_src = 2'b11; end
    push({name, ".D"}, c, 1'b1, z, o, f);

    if (name == "ill" && sel == 0) begin
      for (int i = 0; i < 10; i++) begin
        c = '0; c.illegal = 1'b1;
        push("trap", c, 1'b1, z, o, f);
      end
      retire = 1'b0;
    end

    if (has_exe) begin
      c = '0;
      if (name == "addu")  c.alu_op = 3'b010;
      if (name == "subu")  c.alu_op = 3'b011;
      if (name == "sll")   begin c.alu_op = 3'b100; c.alu_src1 = 1'b1; end
      if (name == "ori")   begin c.alu_op = 3'b001; c.ext_op = 2'b00; c.alu_src2 = 2'b01; end
      if (name == "addiu" || name == "lw" || name == "sw") begin
        c.alu_op = 3'b010; c.ext_op = 2'b01; c.alu_src2 = 2'b01;
      end
      if (name == "lui")   begin c.alu_op = 3'b001; c.ext_op = 2'b10; c.alu_src2 = 2'b01; end
      if (name == "beq")   begin c.alu_op = 3'b011; c.pc_we = z; c.pc_src = 2'b01; end
      push({name, ".E"}, c, 1'b1, z, o, f);
    end

    if (has_mem) begin
      c = '0;
      if (name == "lw") c.mem_read = 1'b1; else c.mem_write = 1'b1;
      for (int i = 0; i < mwait; i++) push({name, ".Mwait"}, c, 1'b0, z, o, f);
      if (abort_mem) begin
        has_wb = 1'b0;
        retire = 1'b0;
      end else begin
        push({name, ".M"}, c, 1'b1, z, o, f);
      end
    end

    if (has_wb) begin
      c = '0; c.reg_write = 1'b1;
      if (name == "addu" || name == "subu" || name == "sll") c.reg_dst = 2'b01;
      if (name == "lw") c.mem_to_reg = 2'b01;
      if (name == "jal") begin
        c.reg_dst = 2'b10; c.mem_to_reg = 2'b10; c.pc_we = 1'b1; c.pc_src = 2'b10;
      end
      push({name, ".W"}, c, 1'b1, z, o, f);
    end

    drain();
    if (retire) ret_model++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    // Configuration 0: no handshake, illegal opcode traps, 32-bit counter.
    sel = 0;
    do_reset("a0");
    run_instr("addu",  6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    run_instr("subu",  6'h00, 6'h23, 1'b0, 0, 0, 1'b0);
    run_instr("sll",   6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("ori",   6'h0D, 6'h15, 1'b0, 0, 0, 1'b0);
    run_instr("addiu", 6'h09, 6'h3F, 1'b0, 0, 0, 1'b0);
    run_instr("lui",   6'h0F, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("beq",   6'h04, 6'h00, 1'b1, 0, 0, 1'b0);
    run_instr("beq",   6'h04, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("j",     6'h02, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("jr",    6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
    run_instr("jal",   6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("sw",    6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("lw",    6'h23, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("ill",   6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);
    do_reset("a1");
    run_instr("addu",  6'h00, 6'h21, 1'b0, 0, 0, 1'b0);

    // Configuration 1: memory handshake, illegal retires as NOP, 4-bit counter.
    sel = 1;
    do_reset("b0");
    for (int i = 0; i < 16; i++) run_instr("sw", 6'h2B, 6'h00, 1'b0, 0, 0, 1'b0);
    run_instr("lw",    6'h23, 6'h00, 1'b0, 1, 3, 1'b0);
    run_instr("ill",   6'h00, 6'h3F, 1'b0, 0, 0, 1'b0);
    run_instr("addu",  6'h00, 6'h21, 1'b0, 0, 0, 1'b0);
    run_instr("sw",    6'h2B, 6'h00, 1'b0, 0, 2, 1'b1);
    do_reset("b1");
    run_instr("ori",   6'h0D, 6'h00, 1'b0, 0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
